phys_reg_free_list: RTL and testbench

//  Circular FIFO of free physical-register tags. Feeds T_new to dispatch, which writes it into the ROB.

---
 rtl/ooo_pkg.sv | 19 +
 rtl/phys_reg_free_list_if.sv | 18 +
 rtl/lane_prefix_count.sv | 16 +
 rtl/phys_reg_free_list.sv | 90 +++++++++
 tb/tb_phys_reg_free_list.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared out-of-order core types and sizes for rename, free list and ROB.
package ooo_pkg;
  localparam int PRF_SIZE = 64;
  localparam int RF_SIZE = 32;
  localparam int WIDTH = 2;
  localparam int FL_DEPTH = PRF_SIZE - RF_SIZE;
  localparam int TAG_W = $clog2(PRF_SIZE);
  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef logic [TAG_W-1:0] phys_tag_t;
  typedef logic [$clog2(RF_SIZE)-1:0] arch_tag_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;
  typedef logic [IDX_W-1:0] fl_idx_t;
  typedef logic [CNT_W-1:0] lane_cnt_t;
  function automatic fl_idx_t ptr_idx(fl_ptr_t p);
    return p[IDX_W-1:0];
  endfunction
endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: dispatch/retire/rollback port bundle of the physical register free list.
interface phys_reg_free_list_if;
  import ooo_pkg::*;
  logic [WIDTH-1:0] alloc_req;
  logic alloc_ready;
  phys_tag_t [WIDTH-1:0] alloc_tag;
  fl_ptr_t head_ptr;
  logic [WIDTH-1:0] free_en;
  phys_tag_t [WIDTH-1:0] free_tag;
  logic rollback_en;
  fl_ptr_t rollback_head;
  fl_ptr_t free_count;
  logic free_err;
  modport master(output alloc_req, free_en, free_tag, rollback_en, rollback_head,
                 input alloc_ready, alloc_tag, head_ptr, free_count, free_err);
  modport slave(input alloc_req, free_en, free_tag, rollback_en, rollback_head,
                output alloc_ready, alloc_tag, head_ptr, free_count, free_err);
endinterface

// File: rtl/lane_prefix_count.sv
// lane_prefix_count: exclusive prefix popcount of a lane mask plus its total.
module lane_prefix_count
  import ooo_pkg::*;
(
  input  logic [WIDTH-1:0]      v,
  output lane_cnt_t [WIDTH-1:0] ofs,
  output lane_cnt_t             total
);
  always_comb begin
    total = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ofs[i] = total;
      total = total + lane_cnt_t'(v[i]);
    end
  end
endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical tags with rollback; define FL_DUP_CHECK_EN
// to track membership and drop/flag double frees.
module phys_reg_free_list
  import ooo_pkg::*;
(
  input logic clk,
  input logic rst_n,
  phys_reg_free_list_if.slave fl_if
);
  phys_tag_t fl_q [FL_DEPTH];
  phys_tag_t fl_d [FL_DEPTH];
  fl_ptr_t head_q, head_d, tail_q, tail_d, count;
  lane_cnt_t [WIDTH-1:0] a_ofs, f_ofs;
  lane_cnt_t a_tot, f_tot;
  logic [WIDTH-1:0] f_acc;
  logic [PTR_W:0] occ;
  logic alloc_fire, overflow;
  lane_prefix_count u_aofs (.v(fl_if.alloc_req), .ofs(a_ofs), .total(a_tot));
  lane_prefix_count u_fofs (.v(f_acc), .ofs(f_ofs), .total(f_tot));
  assign count = tail_q - head_q;
  assign fl_if.free_count = count;
  assign fl_if.alloc_ready = count >= fl_ptr_t'(WIDTH);
  assign fl_if.head_ptr = head_q;
  assign alloc_fire = fl_if.alloc_ready && !fl_if.rollback_en;
  // occupancy seen by the frees uses the post-rollback head
  assign occ = {1'b0, fl_ptr_t'(tail_q - (fl_if.rollback_en ? fl_if.rollback_head : head_q))}
             + (PTR_W+1)'(f_tot);
  assign overflow = occ > (PTR_W+1)'(FL_DEPTH);
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      fl_if.alloc_tag[i] = fl_q[ptr_idx(head_q + fl_ptr_t'(a_ofs[i]))];
    fl_d = fl_q;
    for (int i = 0; i < WIDTH; i++)
      if (f_acc[i] && !overflow) fl_d[ptr_idx(tail_q + fl_ptr_t'(f_ofs[i]))] = fl_if.free_tag[i];
    head_d = fl_if.rollback_en ? fl_if.rollback_head : alloc_fire ? head_q + fl_ptr_t'(a_tot) : head_q;
    tail_d = overflow ? tail_q : tail_q + fl_ptr_t'(f_tot);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(FL_DEPTH);
      for (int k = 0; k < FL_DEPTH; k++) fl_q[k] <= phys_tag_t'(RF_SIZE + k);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fl_q <= fl_d;
    end
  assert property (@(posedge clk) disable iff (!rst_n) !overflow);
`ifdef FL_DUP_CHECK_EN
  logic [PRF_SIZE-1:0] in_list_q, in_list_d;
  logic [WIDTH-1:0] dup;
  logic free_err_q, free_err_d;
  fl_ptr_t span;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      dup[i] = in_list_q[fl_if.free_tag[i]];
      for (int j = 0; j < i; j++)
        if (fl_if.free_en[j] && fl_if.free_tag[j] == fl_if.free_tag[i]) dup[i] = 1'b1;
    end
    f_acc = fl_if.free_en & ~dup;
    free_err_d = |(fl_if.free_en & dup);
  end
  always_comb begin
    in_list_d = in_list_q;
    span = head_q - fl_if.rollback_head;
    // squashed slots sit in [rollback_head, head) and become free again
    if (fl_if.rollback_en)
      for (int k = 0; k < FL_DEPTH; k++)
        if ({1'b0, fl_idx_t'(k) - ptr_idx(fl_if.rollback_head)} < span) in_list_d[fl_q[k]] = 1'b1;
    if (alloc_fire)
      for (int i = 0; i < WIDTH; i++)
        if (fl_if.alloc_req[i]) in_list_d[fl_if.alloc_tag[i]] = 1'b0;
    if (!overflow)
      for (int i = 0; i < WIDTH; i++)
        if (f_acc[i]) in_list_d[fl_if.free_tag[i]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_list_q <= {{FL_DEPTH{1'b1}}, {RF_SIZE{1'b0}}};
      free_err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      free_err_q <= free_err_d;
    end
  assign fl_if.free_err = free_err_q;
`else
  assign f_acc = fl_if.free_en;
  assign fl_if.free_err = 1'b0;
`endif
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: scoreboard bench; a queue-based free-tag model plus an allocation
// history stack predicts every offer, count, head and error flag.
module tb_phys_reg_free_list;
  import ooo_pkg::*;
  typedef struct {string tag; int kind; int exp;} sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  phys_reg_free_list_if ifc();
  phys_reg_free_list dut (.clk(clk), .rst_n(rst_n), .fl_if(ifc.slave));
  always #5 clk = ~clk;
  int nvec = 0, nerr = 0;
  int free_q[$], hist[$];
  int mhead;
  bit exp_err;
  sb_t sb[$];
  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int act(int k);
    case (k)
      0: return int'(ifc.free_count);
      1: return int'(ifc.alloc_ready);
      2: return int'(ifc.head_ptr);
      3: return int'(ifc.free_err);
      4: return int'(ifc.alloc_tag[0]);
      default: return int'(ifc.alloc_tag[1]);
    endcase
  endfunction
  function automatic bit in_q(int t);
    foreach (free_q[k]) if (free_q[k] == t) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_reset();
    free_q.delete();
    hist.delete();
    for (int k = 0; k < FL_DEPTH; k++) free_q.push_back(RF_SIZE + k);
    mhead = 0;
    exp_err = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    ifc.alloc_req = '0; ifc.free_en = '0; ifc.rollback_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", act(0), FL_DEPTH);
    chk("async_rst_head", act(2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic step(input bit [1:0] req, input bit [1:0] fen, input int t0, input int t1,
                      input bit rb, input int rbh);
    int ofs, n;
    int ft[2];
    bit [1:0] dup;
    bit err_n;
    sb_t e;
    ft[0] = t0; ft[1] = t1;
    @(negedge clk);
    ifc.alloc_req = req; ifc.free_en = fen;
    ifc.free_tag[0] = phys_tag_t'(t0); ifc.free_tag[1] = phys_tag_t'(t1);
    ifc.rollback_en = rb; ifc.rollback_head = fl_ptr_t'(rbh);
    sb.push_back('{"count", 0, free_q.size()});
    sb.push_back('{"ready", 1, int'(free_q.size() >= WIDTH)});
    sb.push_back('{"head", 2, mhead});
    sb.push_back('{"free_err", 3, int'(exp_err)});
    ofs = 0;
    for (int i = 0; i < WIDTH; i++)
      if (req[i]) begin
        if (ofs < free_q.size()) sb.push_back('{i == 0 ? "alloc_tag0" : "alloc_tag1", 4 + i, free_q[ofs]});
        ofs++;
      end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, act(e.kind), e.exp);
    end
    dup = '0;
    err_n = 1'b0;
`ifdef FL_DUP_CHECK_EN
    for (int i = 0; i < WIDTH; i++)
      if (fen[i]) begin
        dup[i] = in_q(ft[i]) || (i == 1 && fen[0] && ft[0] == ft[1]);
        err_n |= dup[i];
      end
`endif
    if (rb) begin
      n = (mhead - rbh) & 63;
      repeat (n) free_q.push_front(hist.pop_back());
      mhead = rbh;
    end else if (free_q.size() >= WIDTH) begin
      for (int i = 0; i < WIDTH; i++)
        if (req[i]) begin
          hist.push_back(free_q.pop_front());
          mhead = (mhead + 1) & 63;
        end
    end
    for (int i = 0; i < WIDTH; i++) if (fen[i] && !dup[i]) free_q.push_back(ft[i]);
    exp_err = err_n;
  endtask
  initial begin
    int cp;
    bit [1:0] rq, fe;
    int t[2];
    ifc.alloc_req = '0; ifc.free_en = '0; ifc.free_tag = '0;
    ifc.rollback_en = 1'b0; ifc.rollback_head = '0;
    do_reset();
    // rollback restores squashed tags; same-cycle free still appends
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0);
    cp = mhead;
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 1, cp);
    step(2'b01, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b00, 2'b01, 3, 0, 1, cp);
    step(2'b10, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
    for (int c = 0; c < 60; c++) begin
      rq = 2'($urandom_range(0, 3));
      fe = '0;
      t[0] = 0; t[1] = 0;
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 1) == 1 && hist.size() > 0 && free_q.size() + $countones(fe) < FL_DEPTH) begin
          fe[i] = 1'b1;
          t[i] = hist.pop_front();
        end
      step(rq, fe, t[0], t[1], 0, 0);
    end
    // drain from reset, then refill with two tags and starve at free_count=1
    do_reset();
    repeat (16) step(2'b11, 0, 0, 0, 0, 0);
    step(2'b00, 2'b11, 5, 9, 0, 0);
    step(2'b01, 0, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
`ifdef FL_DUP_CHECK_EN
    do_reset();
    step(2'b11, 0, 0, 0, 0, 0);
    step(2'b00, 2'b01, 40, 0, 0, 0);
    step(2'b00, 2'b11, 33, 33, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
